cross_bar_bank_port: RTL

Per-bank output stage of the cross bar, one instance per bank (4 total), directly downstream of the per-channel entry selection. Each cycle it round-robin arbitrates among the channels that hold a pending request for this bank. It returns a one-hot grant so the winning channel clears its entry valid bit, and buffers the winner in a small FIFO. The FIFO drives the bank with a valid/ready handshake.

---
 rtl/cross_bar_bank_port_if.sv | 47 ++++
 rtl/cross_bar_bank_port.sv | 105 ++++++++++
 2 files changed

// File: rtl/cross_bar_bank_port_if.sv
// Channel-request and bank-side handshake bundle for one cross bar bank port.
// slave: the bank port; master: upstream channels plus bank model.
interface cross_bar_bank_port_if #(
  parameter int NUM_CH    = 3,
  parameter int ENTRY_W   = 3,
  parameter int PAYLOAD_W = 64,
  parameter int BUF_DEPTH = 2
);
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  logic [NUM_CH-1:0]           ch_req_valid_i;
  logic [NUM_CH*ENTRY_W-1:0]   ch_req_entry_i;
  logic [NUM_CH*PAYLOAD_W-1:0] ch_req_payload_i;
  logic [NUM_CH-1:0]           ch_grant_o;
  logic                        bank_valid_o;
  logic                        bank_ready_i;
  logic [1:0]                  bank_ch_id_o;
  logic [ENTRY_W-1:0]          bank_entry_o;
  logic [PAYLOAD_W-1:0]        bank_payload_o;
  logic [CNT_W-1:0]            buf_cnt_o;

  modport slave (
    input  ch_req_valid_i,
    input  ch_req_entry_i,
    input  ch_req_payload_i,
    input  bank_ready_i,
    output ch_grant_o,
    output bank_valid_o,
    output bank_ch_id_o,
    output bank_entry_o,
    output bank_payload_o,
    output buf_cnt_o
  );

  modport master (
    output ch_req_valid_i,
    output ch_req_entry_i,
    output ch_req_payload_i,
    output bank_ready_i,
    input  ch_grant_o,
    input  bank_valid_o,
    input  bank_ch_id_o,
    input  bank_entry_o,
    input  bank_payload_o,
    input  buf_cnt_o
  );
endinterface

// File: rtl/cross_bar_bank_port.sv
// Per-bank round-robin arbiter feeding a small output FIFO toward the bank.
// Optional CROSS_BAR_BANK_BYPASS_EN: zero-latency path when FIFO empty and bank ready.
module cross_bar_bank_port #(
  parameter int NUM_CH    = 3,
  parameter int ENTRY_W   = 3,
  parameter int PAYLOAD_W = 64,
  parameter int BUF_DEPTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  cross_bar_bank_port_if.slave bus
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [1:0]           rr_ptr_q;
  logic [1:0]           cand;
  logic [1:0]           g_id;
  logic                 g_vld;
  logic [NUM_CH-1:0]    grant;
  logic [ENTRY_W-1:0]   g_entry;
  logic [PAYLOAD_W-1:0] g_pl;

  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 push;
  logic                 pop;
  logic                 bypass;

  logic [1:0]           mem_ch    [BUF_DEPTH];
  logic [ENTRY_W-1:0]   mem_entry [BUF_DEPTH];
  logic [PAYLOAD_W-1:0] mem_pl    [BUF_DEPTH];

  // A pop this cycle never frees a slot for a push this cycle.
  always_comb begin
    grant = '0;
    g_vld = 1'b0;
    g_id  = '0;
    cand  = '0;
    if (cnt_q < CNT_W'(BUF_DEPTH)) begin
      for (int k = 0; k < NUM_CH; k++) begin
        cand = 2'((int'(rr_ptr_q) + k) % NUM_CH);
        if (!g_vld && bus.ch_req_valid_i[cand]) begin
          g_vld = 1'b1;
          g_id  = cand;
        end
      end
    end
    if (g_vld) grant[g_id] = 1'b1;
  end

  assign g_entry = bus.ch_req_entry_i[int'(g_id)*ENTRY_W +: ENTRY_W];
  assign g_pl    = bus.ch_req_payload_i[int'(g_id)*PAYLOAD_W +: PAYLOAD_W];

`ifdef CROSS_BAR_BANK_BYPASS_EN
  assign bypass = g_vld & (cnt_q == '0) & bus.bank_ready_i;
`else
  assign bypass = 1'b0;
`endif

  assign push = g_vld & ~bypass;
  assign pop  = (cnt_q != '0) & bus.bank_ready_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_ptr_q <= '0;
    end else if (g_vld) begin
      rr_ptr_q <= (g_id == 2'(NUM_CH-1)) ? 2'd0 : 2'(g_id + 2'd1);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_ch[i]    <= '0;
        mem_entry[i] <= '0;
        mem_pl[i]    <= '0;
      end
    end else begin
      if (push) begin
        mem_ch[wr_ptr_q]    <= g_id;
        mem_entry[wr_ptr_q] <= g_entry;
        mem_pl[wr_ptr_q]    <= g_pl;
        wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign bus.ch_grant_o     = grant;
  assign bus.buf_cnt_o      = cnt_q;
  assign bus.bank_valid_o   = (cnt_q != '0) | bypass;
  assign bus.bank_ch_id_o   = bypass ? g_id    : mem_ch[rd_ptr_q];
  assign bus.bank_entry_o   = bypass ? g_entry : mem_entry[rd_ptr_q];
  assign bus.bank_payload_o = bypass ? g_pl    : mem_pl[rd_ptr_q];
endmodule
